// File: rtl/vermibus_arbiter.sv
// Vermibus N:1 arbiter: merges N requesters onto one target bus with zero-latency
// grant in IDLE and a grant lock held until the transaction completes.
module vermibus_arbiter #(
  parameter int N           = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           s_valid,
  input  logic [N*32-1:0]        s_address,
  input  logic [N*4-1:0]         s_wstrobe,
  input  logic [N*32-1:0]        s_wdata,
  output logic [31:0]            s_rdata,
  output logic [N-1:0]           s_ready,
  output logic [N-1:0]           s_irq,
  output logic                   m_valid,
  output logic [31:0]            m_address,
  output logic [3:0]             m_wstrobe,
  output logic [31:0]            m_wdata,
  input  logic [31:0]            m_rdata,
  input  logic                   m_ready,
  input  logic                   m_irq,
  output logic [$clog2(N)-1:0]   m_grant
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   lock_idx_reg, lock_idx_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic [IW-1:0]   arb_idx, grant_idx;
  logic            active, done;

  logic [31:0]     addr_arr  [N];
  logic [3:0]      wstrb_arr [N];
  logic [31:0]     wdata_arr [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign addr_arr[gi]  = s_address[32*gi +: 32];
      assign wstrb_arr[gi] = s_wstrobe[4*gi +: 4];
      assign wdata_arr[gi] = s_wdata[32*gi +: 32];
    end
  endgenerate

  assign s_rdata = m_rdata;
  assign s_irq   = {N{m_irq}};

  // Descending scan so the candidate closest to the search origin wins.
  always_comb begin
    int idx;
    idx     = 0;
    arb_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (ROUND_ROBIN != 0) begin
        idx = int'(rr_ptr_reg) + k;
        if (idx >= N) idx = idx - N;
      end else begin
        idx = k;
      end
      if (s_valid[idx]) arb_idx = IW'(idx);
    end
  end

  always_comb begin
    state_next    = state_reg;
    lock_idx_next = lock_idx_reg;
    rr_ptr_next   = rr_ptr_reg;
    grant_next    = grant_reg;
    grant_idx     = (state_reg == LOCKED) ? lock_idx_reg : arb_idx;
    active        = 1'b0;
    if (!reset) active = (state_reg == LOCKED) ? s_valid[grant_idx] : |s_valid;
    done          = active & m_ready;

    m_valid   = active;
    m_address = addr_arr[grant_idx];
    m_wstrobe = wstrb_arr[grant_idx];
    m_wdata   = wdata_arr[grant_idx];
    s_ready   = '0;
    if (done) s_ready[grant_idx] = 1'b1;
    m_grant   = active ? grant_idx : grant_reg;
    if (active) grant_next = grant_idx;

    case (state_reg)
      IDLE: begin
        if (active && !m_ready) begin
          state_next    = LOCKED;
          lock_idx_next = grant_idx;
        end
      end
      LOCKED: begin
        // Requester withdrew mid-transaction: release without moving the pointer.
        if (!active) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (done) begin
      state_next  = IDLE;
      rr_ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      lock_idx_reg <= '0;
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      lock_idx_reg <= lock_idx_next;
      rr_ptr_reg   <= rr_ptr_next;
      grant_reg    <= grant_next;
    end
  end

endmodule

// File: tb/tb_vermibus_arbiter.sv
// Self-checking bench for vermibus_arbiter: N=2 round-robin, N=4 fixed priority,
// N=3 round-robin; completions on the N=2 instance are scored against a queue.
module tb_vermibus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [3:0]  ws;
    logic [31:0] wd;
  } txn_t;
  txn_t q2[$];

  // N=2 round-robin
  logic [1:0]  v2, rdy2, irq2;
  logic [63:0] a2, wd2;
  logic [7:0]  ws2;
  logic [31:0] rd2, ma2, mwd2, mrd2;
  logic [3:0]  mws2;
  logic        mv2, mr2, mirq2;
  logic [0:0]  mg2;

  // N=4 fixed priority
  logic [3:0]   v4, rdy4, irq4;
  logic [127:0] a4, wd4;
  logic [15:0]  ws4;
  logic [31:0]  rd4, ma4, mwd4, mrd4;
  logic [3:0]   mws4;
  logic         mv4, mr4, mirq4;
  logic [1:0]   mg4;

  // N=3 round-robin
  logic [2:0]  v3, rdy3, irq3;
  logic [95:0] a3, wd3;
  logic [11:0] ws3;
  logic [31:0] rd3, ma3, mwd3, mrd3;
  logic [3:0]  mws3;
  logic        mv3, mr3, mirq3;
  logic [1:0]  mg3;

  vermibus_arbiter #(.N(2), .ROUND_ROBIN(1)) dut2 (
    .clk(clk), .reset(reset), .s_valid(v2), .s_address(a2), .s_wstrobe(ws2),
    .s_wdata(wd2), .s_rdata(rd2), .s_ready(rdy2), .s_irq(irq2), .m_valid(mv2),
    .m_address(ma2), .m_wstrobe(mws2), .m_wdata(mwd2), .m_rdata(mrd2),
    .m_ready(mr2), .m_irq(mirq2), .m_grant(mg2));

  vermibus_arbiter #(.N(4), .ROUND_ROBIN(0)) dut4 (
    .clk(clk), .reset(reset), .s_valid(v4), .s_address(a4), .s_wstrobe(ws4),
    .s_wdata(wd4), .s_rdata(rd4), .s_ready(rdy4), .s_irq(irq4), .m_valid(mv4),
    .m_address(ma4), .m_wstrobe(mws4), .m_wdata(mwd4), .m_rdata(mrd4),
    .m_ready(mr4), .m_irq(mirq4), .m_grant(mg4));

  vermibus_arbiter #(.N(3), .ROUND_ROBIN(1)) dut3 (
    .clk(clk), .reset(reset), .s_valid(v3), .s_address(a3), .s_wstrobe(ws3),
    .s_wdata(wd3), .s_rdata(rd3), .s_ready(rdy3), .s_irq(irq3), .m_valid(mv3),
    .m_address(ma3), .m_wstrobe(mws3), .m_wdata(mwd3), .m_rdata(mrd3),
    .m_ready(mr3), .m_irq(mirq3), .m_grant(mg3));

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    v2 = 2'b11; v3 = 3'b111; v4 = 4'b1111;
    mr2 = 1'b1; mr3 = 1'b1; mr4 = 1'b1;
    @(negedge clk);
    checks++; if (mv2 !== 1'b0) begin errors++; $display("FAIL reset_mvalid2 got %0b want 0", mv2); end
    checks++; if (rdy2 !== 2'b00) begin errors++; $display("FAIL reset_ready2 got %b want 00", rdy2); end
    checks++; if (mg2 !== 1'b0) begin errors++; $display("FAIL reset_grant2 got %0d want 0", mg2); end
    checks++; if (mv3 !== 1'b0 || rdy3 !== 3'b000) begin errors++; $display("FAIL reset_dut3 got mv=%0b rdy=%b want 0/000", mv3, rdy3); end
    checks++; if (mv4 !== 1'b0 || rdy4 !== 4'b0000) begin errors++; $display("FAIL reset_dut4 got mv=%0b rdy=%b want 0/0000", mv4, rdy4); end
    v2 = '0; v3 = '0; v4 = '0; mr2 = 1'b0; mr3 = 1'b0; mr4 = 1'b0;
    next_cycle();
    reset = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_single;
    txn_t t;
    a2 = {32'h0000_1000, 32'h0000_0000}; ws2 = '0; wd2 = '0;
    v2 = 2'b01; mr2 = 1'b1;
    q2.push_back(txn_t'{port: 0, addr: 32'h0, ws: 4'h0, wd: 32'h0});
    @(negedge clk);
    checks++; if (mv2 !== 1'b1) begin errors++; $display("FAIL single_mvalid got %0b want 1", mv2); end
    checks++; if (ma2 !== 32'h0) begin errors++; $display("FAIL single_addr got %h want 00000000", ma2); end
    checks++; if (rdy2 !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", rdy2); end
    if (rdy2 != 2'b00) begin
      checks++;
      if (q2.size() == 0) begin errors++; $display("FAIL sb_single unexpected ready %b want none", rdy2); end
      else begin
        t = q2.pop_front();
        if (rdy2 !== 2'(1 << t.port) || ma2 !== t.addr || mws2 !== t.ws || mwd2 !== t.wd) begin
          errors++; $display("FAIL sb_single got rdy=%b addr=%h want port %0d addr=%h", rdy2, ma2, t.port, t.addr);
        end
      end
    end
    $display("single: port0 addr=%h rdy=%b", ma2, rdy2);
    next_cycle();
    // rr_ptr should now be 1, so port 1 wins a simultaneous request
    v2 = 2'b11;
    q2.push_back(txn_t'{port: 1, addr: 32'h0000_1000, ws: 4'h0, wd: 32'h0});
    @(negedge clk);
    checks++; if (mg2 !== 1'b1) begin errors++; $display("FAIL single_rrptr got grant %0d want 1", mg2); end
    if (rdy2 != 2'b00) begin
      checks++;
      if (q2.size() == 0) begin errors++; $display("FAIL sb_single2 unexpected ready %b want none", rdy2); end
      else begin
        t = q2.pop_front();
        if (rdy2 !== 2'(1 << t.port) || ma2 !== t.addr) begin
          errors++; $display("FAIL sb_single2 got rdy=%b addr=%h want port %0d addr=%h", rdy2, ma2, t.port, t.addr);
        end
      end
    end
    $display("single: grant=%0d addr=%h rdy=%b", mg2, ma2, rdy2);
    next_cycle();
    v2 = '0; mr2 = 1'b0;
  endtask

  task automatic test_back_to_back;
    txn_t t;
    int   exp_port [5] = '{0, 1, 0, 1, 0};
    logic [1:0] vtab [5] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    a2 = {32'h0000_2004, 32'h0000_2000};
    mr2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v2 = vtab[i];
      q2.push_back(txn_t'{port: exp_port[i], addr: (exp_port[i] == 1) ? 32'h2004 : 32'h2000, ws: 4'h0, wd: 32'h0});
      @(negedge clk);
      checks++; if (mg2 !== 1'(exp_port[i])) begin errors++; $display("FAIL b2b_grant[%0d] got %0d want %0d", i, mg2, exp_port[i]); end
      checks++; if (rdy2 !== 2'(1 << exp_port[i])) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", i, rdy2, 2'(1 << exp_port[i])); end
      if (rdy2 != 2'b00) begin
        checks++;
        if (q2.size() == 0) begin errors++; $display("FAIL sb_b2b unexpected ready %b want none", rdy2); end
        else begin
          t = q2.pop_front();
          if (rdy2 !== 2'(1 << t.port) || ma2 !== t.addr) begin
            errors++; $display("FAIL sb_b2b got rdy=%b addr=%h want port %0d addr=%h", rdy2, ma2, t.port, t.addr);
          end
        end
      end
      $display("b2b[%0d]: grant=%0d rdy=%b", i, mg2, rdy2);
      next_cycle();
    end
    v2 = '0; mr2 = 1'b0;
  endtask

  task automatic test_lock;
    txn_t t;
    a2  = {32'h0000_A100, 32'h0000_B200};
    ws2 = {4'b1111, 4'b0000};
    wd2 = {32'h0000_0096, 32'h0000_0000};
    q2.push_back(txn_t'{port: 1, addr: 32'h0000_A100, ws: 4'b1111, wd: 32'h96});
    for (int c = 0; c < 4; c++) begin
      v2  = (c == 0) ? 2'b10 : 2'b11;
      mr2 = (c == 3);
      @(negedge clk);
      checks++; if (mg2 !== 1'b1 || mv2 !== 1'b1) begin errors++; $display("FAIL lock_grant[%0d] got grant=%0d mv=%0b want 1/1", c, mg2, mv2); end
      checks++; if (ma2 !== 32'h0000_A100 || mws2 !== 4'b1111 || mwd2 !== 32'h96) begin
        errors++; $display("FAIL lock_payload[%0d] got %h/%b/%h want 0000a100/1111/00000096", c, ma2, mws2, mwd2);
      end
      checks++; if (rdy2 !== ((c == 3) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL lock_ready[%0d] got %b want %b", c, rdy2, (c == 3) ? 2'b10 : 2'b00); end
      if (rdy2 != 2'b00) begin
        checks++;
        if (q2.size() == 0) begin errors++; $display("FAIL sb_lock unexpected ready %b want none", rdy2); end
        else begin
          t = q2.pop_front();
          if (rdy2 !== 2'(1 << t.port) || ma2 !== t.addr || mws2 !== t.ws || mwd2 !== t.wd) begin
            errors++; $display("FAIL sb_lock got rdy=%b addr=%h want port %0d addr=%h", rdy2, ma2, t.port, t.addr);
          end
        end
      end
      $display("lock[%0d]: grant=%0d addr=%h rdy=%b", c, mg2, ma2, rdy2);
      next_cycle();
    end
    v2 = 2'b01; mr2 = 1'b1;
    q2.push_back(txn_t'{port: 0, addr: 32'h0000_B200, ws: 4'b0000, wd: 32'h0});
    @(negedge clk);
    checks++; if (mg2 !== 1'b0) begin errors++; $display("FAIL lock_after got grant %0d want 0", mg2); end
    if (rdy2 != 2'b00) begin
      checks++;
      if (q2.size() == 0) begin errors++; $display("FAIL sb_lock2 unexpected ready %b want none", rdy2); end
      else begin
        t = q2.pop_front();
        if (rdy2 !== 2'(1 << t.port) || ma2 !== t.addr) begin
          errors++; $display("FAIL sb_lock2 got rdy=%b addr=%h want port %0d addr=%h", rdy2, ma2, t.port, t.addr);
        end
      end
    end
    $display("lock: after release grant=%0d rdy=%b", mg2, rdy2);
    next_cycle();
    v2 = '0; mr2 = 1'b0;
  endtask

  task automatic test_drop;
    txn_t t;
    v2 = 2'b10; mr2 = 1'b0;
    @(negedge clk);
    checks++; if (mg2 !== 1'b1 || mv2 !== 1'b1) begin errors++; $display("FAIL drop_lock got grant=%0d mv=%0b want 1/1", mg2, mv2); end
    next_cycle();
    v2 = 2'b01;
    @(negedge clk);
    checks++; if (mv2 !== 1'b0 || rdy2 !== 2'b00) begin errors++; $display("FAIL drop_abort got mv=%0b rdy=%b want 0/00", mv2, rdy2); end
    $display("drop: mv=%0b rdy=%b", mv2, rdy2);
    next_cycle();
    // pointer unchanged by the abort, so port 1 still wins
    v2 = 2'b11; mr2 = 1'b1;
    q2.push_back(txn_t'{port: 1, addr: 32'h0000_A100, ws: 4'b1111, wd: 32'h96});
    @(negedge clk);
    checks++; if (mg2 !== 1'b1) begin errors++; $display("FAIL drop_rrptr got grant %0d want 1", mg2); end
    if (rdy2 != 2'b00) begin
      checks++;
      if (q2.size() == 0) begin errors++; $display("FAIL sb_drop unexpected ready %b want none", rdy2); end
      else begin
        t = q2.pop_front();
        if (rdy2 !== 2'(1 << t.port) || ma2 !== t.addr) begin
          errors++; $display("FAIL sb_drop got rdy=%b addr=%h want port %0d addr=%h", rdy2, ma2, t.port, t.addr);
        end
      end
    end
    next_cycle();
    v2 = 2'b00;
    @(negedge clk);
    checks++; if (mv2 !== 1'b0 || rdy2 !== 2'b00 || mg2 !== 1'b1) begin
      errors++; $display("FAIL idle_hold got mv=%0b rdy=%b grant=%0d want 0/00/1", mv2, rdy2, mg2);
    end
    $display("drop: idle grant held=%0d", mg2);
    next_cycle();
    mr2 = 1'b0;
  endtask

  task automatic test_irq_rdata;
    mirq2 = 1'b1; mirq3 = 1'b1; mirq4 = 1'b1;
    mrd2 = 32'h8C15_F3E4; mrd3 = 32'h8C15_F3E4; mrd4 = 32'h8C15_F3E4;
    @(negedge clk);
    checks++; if (irq2 !== 2'b11 || irq3 !== 3'b111 || irq4 !== 4'b1111) begin
      errors++; $display("FAIL irq_high got %b/%b/%b want all ones", irq2, irq3, irq4);
    end
    checks++; if (rd2 !== 32'h8C15_F3E4 || rd3 !== 32'h8C15_F3E4 || rd4 !== 32'h8C15_F3E4) begin
      errors++; $display("FAIL rdata got %h/%h/%h want 8c15f3e4", rd2, rd3, rd4);
    end
    $display("irq: s_irq=%b s_rdata=%h", irq2, rd2);
    next_cycle();
    mirq2 = 1'b0; mrd2 = 32'h0000_1234;
    @(negedge clk);
    checks++; if (irq2 !== 2'b00 || rd2 !== 32'h0000_1234) begin
      errors++; $display("FAIL irq_low got irq=%b rdata=%h want 00/00001234", irq2, rd2);
    end
    $display("irq: s_irq=%b s_rdata=%h", irq2, rd2);
    next_cycle();
    mirq3 = 1'b0; mirq4 = 1'b0;
  endtask

  task automatic test_fixed_priority;
    logic [3:0] vtab [5] = '{4'b1110, 4'b1111, 4'b1000, 4'b1100, 4'b1111};
    int         exp_g [5] = '{1, 0, 3, 2, 0};
    for (int i = 0; i < 4; i++) a4[32*i +: 32] = 32'h100 * i;
    mr4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v4 = vtab[i];
      @(negedge clk);
      checks++; if (mg4 !== 2'(exp_g[i]) || ma4 !== 32'h100 * exp_g[i]) begin
        errors++; $display("FAIL fixed_grant[%0d] got %0d addr=%h want %0d", i, mg4, ma4, exp_g[i]);
      end
      checks++; if (rdy4 !== 4'(1 << exp_g[i])) begin errors++; $display("FAIL fixed_ready[%0d] got %b want %b", i, rdy4, 4'(1 << exp_g[i])); end
      $display("fixed[%0d]: s_valid=%b grant=%0d rdy=%b", i, v4, mg4, rdy4);
      next_cycle();
    end
    v4 = '0; mr4 = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [2:0] vtab [3] = '{3'b111, 3'b101, 3'b110};
    int         exp_g [3] = '{0, 2, 1};
    v3 = 3'b100; mr3 = 1'b0;
    @(negedge clk);
    checks++; if (mg3 !== 2'd2) begin errors++; $display("FAIL rstmid_grant got %0d want 2", mg3); end
    next_cycle();
    v3 = 3'b111;
    @(negedge clk);
    checks++; if (mg3 !== 2'd2 || mv3 !== 1'b1) begin errors++; $display("FAIL rstmid_locked got grant=%0d mv=%0b want 2/1", mg3, mv3); end
    next_cycle();
    reset = 1'b1; mr3 = 1'b1;
    @(negedge clk);
    checks++; if (mv3 !== 1'b0 || rdy3 !== 3'b000 || mg3 !== 2'd0) begin
      errors++; $display("FAIL rstmid_abort got mv=%0b rdy=%b grant=%0d want 0/000/0", mv3, rdy3, mg3);
    end
    $display("rstmid: abort mv=%0b rdy=%b", mv3, rdy3);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v3 = vtab[i];
      @(negedge clk);
      checks++; if (mg3 !== 2'(exp_g[i]) || rdy3 !== 3'(1 << exp_g[i])) begin
        errors++; $display("FAIL rstmid_rr[%0d] got grant=%0d rdy=%b want %0d", i, mg3, rdy3, exp_g[i]);
      end
      $display("rstmid[%0d]: s_valid=%b grant=%0d rdy=%b", i, v3, mg3, rdy3);
      next_cycle();
    end
    v3 = '0; mr3 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    v2 = '0; a2 = '0; ws2 = '0; wd2 = '0; mrd2 = '0; mr2 = 1'b0; mirq2 = 1'b0;
    v4 = '0; a4 = '0; ws4 = '0; wd4 = '0; mrd4 = '0; mr4 = 1'b0; mirq4 = 1'b0;
    v3 = '0; a3 = '0; ws3 = '0; wd3 = '0; mrd3 = '0; mr3 = 1'b0; mirq3 = 1'b0;
    next_cycle();
    test_reset();
    test_single();
    test_back_to_back();
    test_lock();
    test_drop();
    test_irq_rdata();
    test_fixed_priority();
    test_reset_mid();
    checks++;
    if (q2.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d pending want 0", q2.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vermibus_arbiter.md
VERMIBUS_ARBITER -- requirements
Module: vermibus_arbiter

Interface
REQ-001 SHALL have parameter N, default 2, number of requester ports (2..8).
REQ-002 SHALL have parameter ROUND_ROBIN, default 1; 1 = round-robin arbitration, 0 = fixed priority with port 0 highest.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port s_valid, input, N, per-requester request valid.
REQ-007 Port s_address, input, N*32, per-requester byte address; port i occupies bits [32i+31:32i].
REQ-008 Port s_wstrobe, input, N*4, per-requester byte write strobes; 0000 = read.
REQ-009 Port s_wdata, input, N*32, per-requester write data.
REQ-010 Port s_rdata, output, 32, read data, broadcast to all requesters.
REQ-011 Port s_ready, output, N, per-requester completion; at most one bit set.
REQ-012 Port s_irq, output, N, interrupt line, broadcast copy of m_irq.
REQ-013 Port m_valid, m_address (32), m_wstrobe (4), m_wdata (32), outputs: the granted request.
REQ-014 Port m_rdata (32), m_ready (1), m_irq (1), inputs from the target bus.
REQ-015 Port m_grant, output, clog2(N), index of the currently granted requester (debug).

Function
REQ-016 SHALL merge N Vermibus requesters onto one target bus, allowing simultaneous requests (pipelined core: ibus and dbus both valid).
REQ-017 State: IDLE or LOCKED; register lock_idx (clog2(N)); register rr_ptr (clog2(N)).
REQ-018 IDLE: if any s_valid bit is set, grant is chosen combinationally in the same cycle (zero added latency); m_* = selected port's signals.
REQ-019 Round-robin: grant = first set s_valid bit searching from rr_ptr upward, wrapping N-1 -> 0.
REQ-020 Fixed priority: grant = lowest-index set s_valid bit; rr_ptr ignored.
REQ-021 IDLE, no s_valid set: m_valid = 0, s_ready = 0, m_grant holds its last value.
REQ-022 Completion = m_valid & m_ready; s_ready[grant] = m_ready only for the granted port; other s_ready bits 0.
REQ-023 IDLE, grant issued, no completion: next state LOCKED, lock_idx <= grant.
REQ-024 LOCKED: grant = lock_idx regardless of other requests; m_* = that port's signals.
REQ-025 Completion in either state: next state IDLE; rr_ptr <= (grant+1) mod N.
REQ-026 LOCKED and s_valid[lock_idx] drops without completion (protocol violation): m_valid = 0 that cycle, next state IDLE, rr_ptr unchanged.
REQ-027 Completion in IDLE takes one cycle; back-to-back transactions need no idle cycle between them.
REQ-028 s_rdata = m_rdata and s_irq = {N{m_irq}} combinationally at all times.
REQ-029 Grant changes only between transactions; m_address/m_wstrobe/m_wdata stable for the whole transaction.

Reset
REQ-030 While reset = 1: state = IDLE, lock_idx = 0, rr_ptr = 0, m_grant = 0, m_valid = 0, s_ready = 0.
REQ-031 Reset mid-transaction aborts it; no s_ready pulse; first grant after release follows REQ-019/020 with rr_ptr = 0.

Verification
REQ-032 N=2, RR: s_valid=01, addr0=0x00000000, m_ready=1 same cycle -> m_valid=1, m_address=0x0, s_ready=01, rr_ptr=1.
REQ-033 N=2, RR: s_valid=11 held, m_ready=1 each cycle -> grants alternate 1,0,1,0; s_ready alternates 10,01.
REQ-034 N=2: port1 store 0x0000A100/1111/0x00000096 granted, m_ready=0 for 3 cycles while port0 asserts -> grant stays 1, m_* unchanged; on m_ready=1, s_ready=10, next cycle grant=0.
REQ-035 N=4, fixed priority: s_valid=1110 then 1111 -> grant 1 then 0; port 3 granted only when ports 0-2 idle.
REQ-036 N=3: reset asserted while LOCKED on port 2 -> m_valid=0, s_ready=000 immediately; after release with s_valid=111 -> grant=0.
REQ-037 m_irq=1 with any grant state -> s_irq all ones; m_rdata=0x8C15F3E4 -> s_rdata=0x8C15F3E4 on every port.
